// File: rtl/soc_system_ctrl_master_pkg.sv
// Shared types and helpers for the fabric-side Avalon-MM control master.
// Holds the FSM state encoding and the counter sizing rule.
package soc_system_ctrl_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RLAT,
        RESP
    } state_t;

    localparam int READ_LATENCY_MAX = 3;

    // Width needed to hold the value n (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/soc_system_ctrl_master_if.sv
// Command/response port plus Avalon-MM initiator signals.
// master: the control master's view; slave: the environment's view.
interface soc_system_ctrl_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_readdata;
    logic              rsp_error;
    logic              busy;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  avm_readdata, avm_waitrequest,
        output cmd_ready, rsp_valid, rsp_readdata, rsp_error, busy,
        output avm_address, avm_read, avm_write, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output avm_readdata, avm_waitrequest,
        input  cmd_ready, rsp_valid, rsp_readdata, rsp_error, busy,
        input  avm_address, avm_read, avm_write, avm_writedata
    );

endinterface

// File: rtl/soc_system_ctrl_master_timer.sv
// Loadable down-counter shared by the stall timeout and read-latency counts.
// Ports: clk, rst, i_load/i_load_val (reload), i_dec (count), o_last (final count).
module soc_system_ctrl_master_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    // Saturates at zero so a long stall never wraps back to a large count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // High during the cycle that consumes the final count.
    assign o_last = (r_cnt <= W'(1));

endmodule

// File: rtl/soc_system_ctrl_master.sv
// Avalon-MM initiator issuing single transfers from a valid/ready command port.
// Ports: clk, reset (async, active-high), bus (command, response and Avalon signals).
module soc_system_ctrl_master
    import soc_system_ctrl_master_pkg::*;
#(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 32,
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                      clk,
    input logic                      reset,
    soc_system_ctrl_master_if.master bus
);

    localparam int RL   = (READ_LATENCY > READ_LATENCY_MAX) ?
                          READ_LATENCY_MAX : READ_LATENCY;
    localparam int TMAX = (TIMEOUT_CYCLES > RL) ? TIMEOUT_CYCLES : RL;
    localparam int CW   = cnt_w(TMAX);

    state_t            r_state;
    state_t            w_next;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic              w_load;
    logic [CW-1:0]     w_load_val;
    logic              w_dec;
    logic              w_last;
    logic              w_rsp_ld;
    logic [DATA_W-1:0] w_rsp_data;
    logic              w_rsp_err;

    soc_system_ctrl_master_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_last     (w_last)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        w_rsp_ld   = 1'b0;
        w_rsp_data = '0;
        w_rsp_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_next     = REQ;
                    w_load     = 1'b1;
                    w_load_val = CW'(TIMEOUT_CYCLES);
                end
            end
            REQ: begin
                if (!bus.avm_waitrequest) begin
                    if (r_write || (RL == 0)) begin
                        w_next     = RESP;
                        w_rsp_ld   = 1'b1;
                        w_rsp_data = r_write ? '0 : bus.avm_readdata;
                    end else begin
                        w_next     = RLAT;
                        w_load     = 1'b1;
                        w_load_val = CW'(RL);
                    end
                end else begin
                    w_dec = 1'b1;
                    // Zero timeout means wait forever.
                    if ((TIMEOUT_CYCLES != 0) && w_last) begin
                        w_next    = RESP;
                        w_rsp_ld  = 1'b1;
                        w_rsp_err = 1'b1;
                    end
                end
            end
            RLAT: begin
                w_dec = 1'b1;
                if (w_last) begin
                    w_next     = RESP;
                    w_rsp_ld   = 1'b1;
                    w_rsp_data = bus.avm_readdata;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && bus.cmd_valid) begin
                r_write <= bus.cmd_write;
                r_addr  <= bus.cmd_address;
                r_wdata <= bus.cmd_writedata;
            end
            // Response fields update only on entry to RESP, then hold.
            if (w_rsp_ld) begin
                r_rsp_data <= w_rsp_data;
                r_rsp_err  <= w_rsp_err;
            end
        end
    end

    assign bus.cmd_ready     = (r_state == IDLE);
    assign bus.busy          = (r_state != IDLE);
    assign bus.avm_read      = (r_state == REQ) && !r_write;
    assign bus.avm_write     = (r_state == REQ) && r_write;
    assign bus.avm_address   = r_addr;
    assign bus.avm_writedata = r_wdata;
    assign bus.rsp_valid     = (r_state == RESP);
    assign bus.rsp_readdata  = r_rsp_data;
    assign bus.rsp_error     = r_rsp_err;

endmodule

// File: tb/tb_soc_system_ctrl_master.sv
// Bench for the control master: two instances (latency 0 / timeout 256,
// latency 2 / timeout 4) driven by random commands against a slave model.
module tb_soc_system_ctrl_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_address = 2'd0;
    logic [31:0] cmd_writedata = 32'd0;
    logic        waitreq = 1'b0;
    logic [31:0] rdata = 32'd0;

    soc_system_ctrl_master_if #(.ADDR_W(2), .DATA_W(32)) ifa ();
    soc_system_ctrl_master_if #(.ADDR_W(2), .DATA_W(32)) ifb ();

    assign ifa.cmd_valid       = cmd_valid & ~sel;
    assign ifa.cmd_write       = cmd_write;
    assign ifa.cmd_address     = cmd_address;
    assign ifa.cmd_writedata   = cmd_writedata;
    assign ifa.avm_waitrequest = waitreq;
    assign ifa.avm_readdata    = rdata;
    assign ifb.cmd_valid       = cmd_valid & sel;
    assign ifb.cmd_write       = cmd_write;
    assign ifb.cmd_address     = cmd_address;
    assign ifb.cmd_writedata   = cmd_writedata;
    assign ifb.avm_waitrequest = waitreq;
    assign ifb.avm_readdata    = rdata;

    soc_system_ctrl_master #(
        .ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT_CYCLES(256)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    soc_system_ctrl_master #(
        .ADDR_W(2), .DATA_W(32), .READ_LATENCY(2), .TIMEOUT_CYCLES(4)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    logic        m_ready, m_busy, m_read, m_write, m_rsp_valid, m_rsp_err;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata, m_rsp_data;
    assign m_ready     = sel ? ifb.cmd_ready     : ifa.cmd_ready;
    assign m_busy      = sel ? ifb.busy          : ifa.busy;
    assign m_read      = sel ? ifb.avm_read      : ifa.avm_read;
    assign m_write     = sel ? ifb.avm_write     : ifa.avm_write;
    assign m_addr      = sel ? ifb.avm_address   : ifa.avm_address;
    assign m_wdata     = sel ? ifb.avm_writedata : ifa.avm_writedata;
    assign m_rsp_valid = sel ? ifb.rsp_valid     : ifa.rsp_valid;
    assign m_rsp_data  = sel ? ifb.rsp_readdata  : ifa.rsp_readdata;
    assign m_rsp_err   = sel ? ifb.rsp_error     : ifa.rsp_error;

    int rl_of [2] = '{0, 2};
    int to_of [2] = '{256, 4};

    logic [31:0] ref_mem [2][4] = '{default: '0};
    logic [31:0] slv_mem [2][4] = '{default: '0};

    int          checks = 0;
    int          errors = 0;
    int          stall_tgt = 0;
    logic        exp_wr = 1'b0;
    int          req_cur = 0;
    int          req_total = 0;
    int          prot_err = 0;
    int          dly = 0;
    logic [1:0]  lat_addr = 2'd0;
    logic [31:0] lat_data = 32'd0;
    logic [31:0] pend = 32'd0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Avalon slave: stalls each request stall_tgt cycles, then completes it.
    always @(negedge clk) begin
        if (reset) begin
            waitreq = 1'b0;
            rdata   = 32'hDEAD_BEEF;
            req_cur = 0;
            dly     = 0;
        end else begin
            rdata   = $urandom;
            waitreq = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) rdata = pend;
            end
            if (m_ready) req_cur = 0;
            if (m_read || m_write) begin
                if (m_read && m_write) prot_err++;
                if (m_write !== exp_wr) prot_err++;
                if ((req_cur > 0) &&
                    ((m_addr !== lat_addr) || (m_wdata !== lat_data)))
                    prot_err++;
                lat_addr = m_addr;
                lat_data = m_wdata;
                waitreq  = (req_cur < stall_tgt);
                req_cur++;
                req_total++;
                if (!waitreq) begin
                    if (m_write) slv_mem[sel][m_addr] = m_wdata;
                    else if (rl_of[sel] == 0) rdata = slv_mem[sel][m_addr];
                    else begin
                        dly  = rl_of[sel];
                        pend = slv_mem[sel][m_addr];
                    end
                end
            end
        end
    end

    // Issue one command with ns stall cycles and check the outcome.
    task automatic do_cmd(input logic wr, input logic [1:0] a,
                          input logic [31:0] d, input int ns);
        int          to, rl, reqc, exp_cyc, rsp_cnt, rsp_at;
        int          req_base, prot_base;
        bit          tmo;
        logic [31:0] exp_d, got_d;
        logic        got_e;
        to      = to_of[sel];
        rl      = rl_of[sel];
        tmo     = (to != 0) && (ns >= to);
        reqc    = tmo ? to : ns + 1;
        exp_cyc = reqc + ((!wr && !tmo) ? rl : 0) + 1;
        exp_d   = (wr || tmo) ? 32'h0 : ref_mem[sel][a];
        if (wr && !tmo) ref_mem[sel][a] = d;
        @(negedge clk);
        check("cmd_ready", 32'(m_ready), 32'(1));
        stall_tgt     = ns;
        exp_wr        = wr;
        req_base      = req_total;
        prot_base     = prot_err;
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_address   = a;
        cmd_writedata = d;
        rsp_cnt = 0;
        rsp_at  = -1;
        got_d   = 32'h0;
        got_e   = 1'b0;
        for (int c = 1; c <= exp_cyc + 3; c++) begin
            @(negedge clk);
            cmd_valid     = (c <= exp_cyc) ? 1'($urandom) : 1'b0;
            cmd_write     = 1'($urandom);
            cmd_address   = 2'($urandom);
            cmd_writedata = $urandom;
            check("busy", 32'(m_busy), 32'(c <= exp_cyc));
            if (m_rsp_valid) begin
                rsp_cnt++;
                rsp_at = c;
                got_d  = m_rsp_data;
                got_e  = m_rsp_err;
            end
        end
        check("rsp_count", 32'(rsp_cnt), 32'(1));
        check("rsp_cycle", 32'(rsp_at), 32'(exp_cyc));
        check("rsp_readdata", got_d, exp_d);
        check("rsp_error", 32'(got_e), 32'(tmo));
        check("req_cycles", 32'(req_total - req_base), 32'(reqc));
        check("protocol", 32'(prot_err - prot_base), 32'(0));
        check("rsp_hold", m_rsp_data, exp_d);
    endtask

    task automatic reset_state(input string tag);
        check({tag, "_ready"}, 32'(m_ready), 32'(1));
        check({tag, "_busy"}, 32'(m_busy), 32'(0));
        check({tag, "_rw"}, 32'({m_read, m_write}), 32'(0));
        check({tag, "_rsp_valid"}, 32'(m_rsp_valid), 32'(0));
        check({tag, "_rsp_data"}, m_rsp_data, 32'h0);
        check({tag, "_rsp_err"}, 32'(m_rsp_err), 32'(0));
        check({tag, "_addr"}, 32'(m_addr), 32'(0));
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            do_cmd(1'($urandom), 2'($urandom), $urandom,
                   int'($urandom_range(0, 6)));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sel = 1'b0;
        reset_state("rst_a");
        sel = 1'b1;
        reset_state("rst_b");

        // Latency 0 instance: PIO write, read back, stall.
        sel = 1'b0;
        do_cmd(1'b1, 2'd0, 32'h0000_0003, 0);
        check("out_port", 32'(slv_mem[0][0][1:0]), 32'(2'b11));
        do_cmd(1'b0, 2'd0, 32'h0, 0);
        do_cmd(1'b0, 2'd1, 32'h0, 0);
        do_cmd(1'b1, 2'd2, 32'h1234_5678, 5);
        do_cmd(1'b0, 2'd2, 32'h0, 3);
        random_run(30);

        // Reset in the middle of a stalled read.
        @(negedge clk);
        stall_tgt   = 100;
        exp_wr      = 1'b0;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_req_read", 32'(m_read), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("rst_mid_rw", 32'({m_read, m_write}), 32'(0));
        check("rst_mid_rsp", 32'(m_rsp_valid), 32'(0));
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_rsp", 32'(m_rsp_valid), 32'(0));
            check("post_rst_ready", 32'(m_ready), 32'(1));
        end
        stall_tgt = 0;
        do_cmd(1'b0, 2'd0, 32'h0, 0);

        // Latency 2 / timeout 4 instance.
        sel = 1'b1;
        do_cmd(1'b0, 2'd1, 32'h0, 50);
        do_cmd(1'b1, 2'd1, 32'hA5A5_5A5A, 0);
        do_cmd(1'b0, 2'd1, 32'h0, 0);
        do_cmd(1'b1, 2'd3, 32'hCAFE_0001, 4);
        do_cmd(1'b0, 2'd3, 32'h0, 3);
        random_run(30);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
